// File: rtl/instr_encoder_if.sv
// Request/write bus between an instruction producer and instr_encoder.
// slave = encoder side, master = producer/memory side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               is_b_type;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic signed [31:0] imm;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [31:0]        wr_data;

  modport master (
    output in_valid, is_b_type, rd, rs1, rs2, imm,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, is_b_type, rd, rs1, rs2, imm,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes addi/bne requests into RV32 words and writes them to sequential
// instruction-memory addresses. Optional immediate range check: ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  instr_encoder_if.slave    bus,
  output logic              full,
  output logic              err_range,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                full_q, full_d;
  logic                accept;
  logic                reject;

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
  endfunction

  assign accept = bus.in_valid && in_ready_q;

`ifdef ENC_RANGE_CHECK_EN
  logic err_range_q, err_range_d;
  logic err_q, err_d;

  function automatic logic imm_bad(input logic is_b, input logic signed [31:0] imm);
    if (is_b)
      return (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
    return (imm < -32'sd2048) || (imm > 32'sd2047);
  endfunction

  assign reject = accept && imm_bad(bus.is_b_type, bus.imm);

  always_comb begin
    err_range_d = reject && !clr;
    err_d       = clr ? 1'b0 : (err_q || reject);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_range_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_range_q <= err_range_d;
      err_q       <= err_d;
    end
  end

  assign err_range = err_range_q;
  assign err       = err_q;
`else
  assign reject    = 1'b0;
  assign err_range = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (accept && !reject) begin
          state_d   = WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = bus.is_b_type ? enc_b(bus.rs1, bus.rs2, bus.imm)
                                    : enc_i(bus.rd, bus.rs1, bus.imm);
        end
      end
      WRITE: begin
        // The last address parks the counter instead of wrapping to 0.
        if (&cnt_q) begin
          state_d = FULL;
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      FULL:    state_d = FULL;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      wr_en_d = 1'b0;
    end
    in_ready_d = (state_d == IDLE);
    full_d     = (state_d == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      full_q     <= full_d;
    end
  end

  // clr in the WRITE cycle must cancel the write the memory would take at this edge.
  assign bus.wr_en    = wr_en_q && !clr;
  assign bus.in_ready = in_ready_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign full         = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (ADDR_W=2): vector table, corner sequences and
// randomized requests against a reference model of the encoding rules.
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic full, err_range, err;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bus       (bus),
    .full      (full),
    .err_range (err_range),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_addr = 0;
  bit exp_err = 1'b0;

  typedef struct {
    bit          b;
    int          rd, rs1, rs2, imm;
    logic [31:0] word;
    bit          bad;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_enc(input bit b, input int rd, input int rs1,
                                          input int rs2, input int imm);
    int w;
    if (!b)
      w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h13;
    else
      w = (((imm >>> 12) & 1) << 31) | (((imm >>> 5) & 'h3F) << 25) | (rs2 << 20) |
          (rs1 << 15) | (1 << 12) | (((imm >>> 1) & 'hF) << 8) |
          (((imm >>> 11) & 1) << 7) | 'h63;
    return w;
  endfunction

  function automatic bit ref_bad(input bit b, input int imm);
`ifdef ENC_RANGE_CHECK_EN
    if (!b) return (imm < -2048) || (imm > 2047);
    return (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    exp_addr = 0;
    exp_err  = 1'b0;
    chk("clr_full", full, 0);
    chk("clr_ready", bus.in_ready, 1);
    chk("clr_err", err, 0);
  endtask

  task automatic drive_req(input bit b, input int rd, input int rs1, input int rs2,
                           input int imm);
    bus.is_b_type = b;
    bus.rd        = rd[4:0];
    bus.rs1       = rs1[4:0];
    bus.rs2       = rs2[4:0];
    bus.imm       = imm;
    bus.in_valid  = 1'b1;
  endtask

  task automatic apply(input string tag, input bit b, input int rd, input int rs1,
                       input int rs2, input int imm, input logic [31:0] word, input bit rej);
    bit r;
    int waited;
    r = rej;
`ifndef ENC_RANGE_CHECK_EN
    r = 1'b0;
`endif
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      chk({tag, "_ready_timeout"}, bus.in_ready, 1);
      return;
    end
    drive_req(b, rd, rs1, rs2, imm);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    if (r) begin
      exp_err = 1'b1;
      chk({tag, "_rej_wr_en"}, bus.wr_en, 0);
      chk({tag, "_err_range"}, err_range, 1);
      chk({tag, "_err"}, err, 1);
      chk({tag, "_rej_ready"}, bus.in_ready, 1);
    end else begin
      chk({tag, "_wr_en"}, bus.wr_en, 1);
      chk({tag, "_wr_addr"}, bus.wr_addr, exp_addr);
      chk({tag, "_wr_data"}, bus.wr_data, word);
      @(negedge clk);
      exp_addr++;
      chk({tag, "_wr_en_drop"}, bus.wr_en, 0);
      chk({tag, "_full"}, full, (exp_addr == DEPTH) ? 1 : 0);
      chk({tag, "_ready_after"}, bus.in_ready, (exp_addr == DEPTH) ? 0 : 1);
      chk({tag, "_err_sticky"}, err, exp_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int b, rd, rs1, rs2, imm;

    tbl[0] = '{0, 1, 0, 0, 255, 32'h0FF00093, 0};
    tbl[1] = '{1, 0, 1, 0, -4, 32'hFE009EE3, 0};
    tbl[2] = '{0, 31, 31, 0, -1, 32'hFFFF8F93, 0};
    tbl[3] = '{1, 0, 2, 3, 8, 32'h00311463, 0};
    tbl[4] = '{0, 1, 0, 0, 2048, 32'h80000093, 1};
    tbl[5] = '{1, 0, 0, 0, 3, 32'h00001163, 1};
    tbl[6] = '{1, 0, 0, 0, 4094, 32'h7E001FE3, 0};
    tbl[7] = '{0, 5, 6, 0, -2048, 32'h80030293, 0};

    rst_n = 1'b0;
    clr   = 1'b0;
    bus.in_valid = 1'b0;
    drive_req(0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_full", full, 0);
    chk("rst_err_range", err_range, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", bus.in_ready, 0);
    @(negedge clk);
    chk("ready_first_edge", bus.in_ready, 1);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      if (exp_addr == DEPTH) do_clr();
      apply($sformatf("vec%0d", i), tbl[i].b, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
            tbl[i].imm, tbl[i].word, tbl[i].bad);
    end

    // Fill, stay full while requests are offered, then clr restarts at 0
    do_clr();
    for (int i = 0; i < DEPTH; i++)
      apply($sformatf("fill%0d", i), 0, i + 1, i, 0, i * 3, ref_enc(0, i + 1, i, 0, i * 3), 0);
    @(negedge clk);
    drive_req(0, 2, 2, 0, 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_no_wr", bus.wr_en, 0);
      chk("full_hold", full, 1);
      chk("full_not_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    do_clr();
    apply("after_full", 0, 9, 8, 0, 100, ref_enc(0, 9, 8, 0, 100), 0);

    // clr coincident with accept: no write, counter back to 0
    @(negedge clk);
    drive_req(1, 0, 4, 5, -16);
    clr = 1'b1;
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; clr = 1'b0; end
    @(negedge clk);
    chk("clr_accept_no_wr", bus.wr_en, 0);
    chk("clr_accept_ready", bus.in_ready, 1);
    exp_addr = 0;
    exp_err  = 1'b0;
    apply("post_clr_acc", 0, 3, 3, 0, 1, ref_enc(0, 3, 3, 0, 1), 0);

    // clr during the WRITE cycle suppresses that write
    @(negedge clk);
    drive_req(0, 4, 4, 0, 44);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    clr = 1'b1;
    #1 chk("clr_write_wr_en", bus.wr_en, 0);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_write_idle", bus.in_ready, 1);
    exp_addr = 0;
    exp_err  = 1'b0;
    apply("post_clr_wr", 0, 6, 6, 0, 66, ref_enc(0, 6, 6, 0, 66), 0);

    // Reset during WRITE drops wr_en without a clock edge
    @(negedge clk);
    drive_req(0, 7, 7, 0, 77);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_wr_en", bus.wr_en, 1);
    rst_n = 1'b0;
    #1 begin
      chk("async_rst_wr_en", bus.wr_en, 0);
      chk("async_rst_addr", bus.wr_addr, 0);
      chk("async_rst_ready", bus.in_ready, 0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 1);
    exp_addr = 0;
    exp_err  = 1'b0;
    apply("post_rst", 0, 8, 8, 0, 88, ref_enc(0, 8, 8, 0, 88), 0);

    // Randomized requests against the reference model
    for (int n = 0; n < 150; n++) begin
      if (exp_addr == DEPTH) do_clr();
      b   = int'($urandom_range(0, 1));
      rd  = int'($urandom_range(0, 31));
      rs1 = int'($urandom_range(0, 31));
      rs2 = int'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) imm = int'($urandom_range(0, 8191)) - 4096;
      else imm = int'($urandom);
      apply($sformatf("rnd%0d", n), b[0], rd, rs1, rs2, imm,
            ref_enc(b[0], rd, rs1, rs2, imm), ref_bad(b[0], imm));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
